// File: rtl/sync_gen.sv
// Sync pulse generator: fixed-width, fixed-period sync of selectable polarity that
// free-runs or phase-locks to the detector's qualified sync strobe.
module sync_gen #(
    parameter  int PERIOD      = 100,
    parameter  int PULSE_WIDTH = 15,
    parameter  int LOCK_WINDOW = 4,
    parameter  int LOCK_COUNT  = 2,
    localparam int CNT_W       = $clog2(PERIOD)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             Enable,
    input  logic             Polarity,
    input  logic             RefSync,
    input  logic             RefValid,
    output logic             SyncOut,
    output logic             SyncStart,
    output logic [CNT_W-1:0] Count,
    output logic             Locked
);

    localparam int TMO_W = $clog2(2 * PERIOD + 1);
    localparam int RUN_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] PW      = CNT_W'(PULSE_WIDTH);
    localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(LOCK_WINDOW);
    localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(PERIOD - LOCK_WINDOW);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(2 * PERIOD);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_COUNT);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic             pol_lat;
    logic [RUN_W-1:0] run_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    logic             ref_hit;
    logic             in_window;
    logic [CNT_W-1:0] next_count;
    logic             pol_next;
    logic [RUN_W-1:0] run_inc;
    logic [TMO_W-1:0] tmo_inc;

    // Outputs are derived from the count about to be loaded so they stay aligned with Count.
    always_comb begin
        ref_hit    = RefSync & RefValid;
        in_window  = (Count <= WIN_LO) || (Count >= WIN_HI) || (Count == LAST);
        next_count = (ref_hit || (Count == LAST)) ? '0 : Count + CNT_W'(1);
        pol_next   = (next_count == '0) ? Polarity : pol_lat;
        run_inc    = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_W'(1);
        tmo_inc    = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + TMO_W'(1);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            SyncOut   <= 1'b0;
            SyncStart <= 1'b0;
            Count     <= '0;
            Locked    <= 1'b0;
            pol_lat   <= 1'b0;
            run_cnt   <= '0;
            tmo_cnt   <= '0;
        end else if (state == IDLE || !Enable) begin
            // Idle values; a reference arriving here or as Enable falls is ignored.
            Count   <= '0;
            Locked  <= 1'b0;
            run_cnt <= '0;
            tmo_cnt <= '0;
            if (state == IDLE && Enable) begin
                state     <= RUN;
                SyncStart <= 1'b1;
                SyncOut   <= Polarity;
                pol_lat   <= Polarity;
            end else begin
                state     <= IDLE;
                SyncStart <= 1'b0;
                SyncOut   <= ~Polarity;
            end
        end else begin
            Count     <= next_count;
            SyncStart <= (next_count == '0);
            SyncOut   <= (next_count < PW) ? pol_next : ~pol_next;
            if (next_count == '0) begin
                pol_lat <= Polarity;
            end

            tmo_cnt <= ref_hit ? '0 : tmo_inc;

            // Lock loss from an invalid reference outranks any hit or timeout.
            if (!RefValid) begin
                run_cnt <= '0;
                Locked  <= 1'b0;
            end else if (RefSync) begin
                if (in_window) begin
                    run_cnt <= run_inc;
                    Locked  <= (run_inc == RUN_MAX);
                end else begin
                    run_cnt <= '0;
                    Locked  <= 1'b0;
                end
            end else if (tmo_inc == TMO_MAX) begin
                run_cnt <= '0;
                Locked  <= 1'b0;
            end
        end
    end

endmodule
